// File: rtl/native_regbank.sv
// native_regbank
//   Register bank on the native side of the AXI4-Lite-to-native bridge.
//   Word map relative to BASE_ADDR (one word = DATA_WIDTH/8 bytes):
//     0..NUM_CTRL-1 : CTRL[i]   read/write, driven out on CTRL_OUT
//     NUM_CTRL      : STATUS    read-only shadow of STATUS_IN
//     NUM_CTRL+1    : IRQ_PEND  write-1-to-clear, set on IRQ_SRC rising edges
//     NUM_CTRL+2    : IRQ_EN    read/write interrupt enables
//     NUM_CTRL+3    : WR_COUNT  counts WACK pulses, any write clears it
//   Ports:
//     AXI_ACLK, AXI_ARESETN     clock, asynchronous active-low reset
//     WEN/WADDR/WDATA           single-cycle write request
//     WACK                      write completion pulse
//     REN/RADDR                 single-cycle read request
//     RDATA/RVALID              read data (held) and one-cycle valid
//     CTRL_OUT                  flattened CTRL registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//     STATUS_IN                 live datapath status
//     IRQ_SRC, IRQ              level interrupt sources, registered interrupt request
//     DEC_ERR                   one-cycle pulse after an unmapped access
module native_regbank #(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           NUM_CTRL       = 4,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET_VAL = '0,
    parameter int unsigned           IRQ_WIDTH      = 8
) (
    input  logic                           AXI_ACLK,
    input  logic                           AXI_ARESETN,
    input  logic                           WEN,
    input  logic [ADDR_WIDTH-1:0]          WADDR,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WACK,
    input  logic                           REN,
    input  logic [ADDR_WIDTH-1:0]          RADDR,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic                           RVALID,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_OUT,
    input  logic [DATA_WIDTH-1:0]          STATUS_IN,
    input  logic [IRQ_WIDTH-1:0]           IRQ_SRC,
    output logic                           IRQ,
    output logic                           DEC_ERR
);

    localparam int unsigned SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IW    = ADDR_WIDTH - SHIFT;

    localparam logic [IW-1:0] IDX_STATUS = IW'(NUM_CTRL);
    localparam logic [IW-1:0] IDX_PEND   = IW'(NUM_CTRL + 1);
    localparam logic [IW-1:0] IDX_EN     = IW'(NUM_CTRL + 2);
    localparam logic [IW-1:0] IDX_CNT    = IW'(NUM_CTRL + 3);

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_PEND,
        SEL_EN,
        SEL_CNT,
        SEL_NONE
    } sel_t;

    // Addresses below the base borrow out of the subtraction and are unmapped.
    function automatic sel_t f_sel(input logic i_below, input logic [IW-1:0] i_idx);
        if (i_below)               return SEL_NONE;
        if (i_idx < IDX_STATUS)    return SEL_CTRL;
        if (i_idx == IDX_STATUS)   return SEL_STATUS;
        if (i_idx == IDX_PEND)     return SEL_PEND;
        if (i_idx == IDX_EN)       return SEL_EN;
        if (i_idx == IDX_CNT)      return SEL_CNT;
        return SEL_NONE;
    endfunction

    logic [DATA_WIDTH-1:0] r_ctrl [NUM_CTRL];
    logic [DATA_WIDTH-1:0] r_status;
    logic [IRQ_WIDTH-1:0]  r_irq_pend;
    logic [IRQ_WIDTH-1:0]  r_irq_en;
    logic [IRQ_WIDTH-1:0]  r_src_prev;
    logic [DATA_WIDTH-1:0] r_wr_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_irq;
    logic                  r_dec_err;

    logic [ADDR_WIDTH:0]   w_wdiff;
    logic [ADDR_WIDTH:0]   w_rdiff;
    logic [IW-1:0]         w_widx;
    logic [IW-1:0]         w_ridx;
    sel_t                  w_wsel;
    sel_t                  w_rsel;
    logic [IRQ_WIDTH-1:0]  w_pend_clr;
    logic [IRQ_WIDTH-1:0]  w_pend_next;
    logic [DATA_WIDTH-1:0] w_pend_word;
    logic [DATA_WIDTH-1:0] w_en_word;
    logic [DATA_WIDTH-1:0] w_rdata_next;

    always_comb begin
        w_wdiff = {1'b0, WADDR} - {1'b0, BASE_ADDR};
        w_rdiff = {1'b0, RADDR} - {1'b0, BASE_ADDR};
        w_widx  = IW'(w_wdiff[ADDR_WIDTH-1:0] >> SHIFT);
        w_ridx  = IW'(w_rdiff[ADDR_WIDTH-1:0] >> SHIFT);
        w_wsel  = f_sel(w_wdiff[ADDR_WIDTH], w_widx);
        w_rsel  = f_sel(w_rdiff[ADDR_WIDTH], w_ridx);
    end

    // A rising source edge in the same cycle as a W1C of that bit keeps it set.
    always_comb begin
        w_pend_clr  = (WEN && (w_wsel == SEL_PEND)) ? WDATA[IRQ_WIDTH-1:0] : '0;
        w_pend_next = (r_irq_pend & ~w_pend_clr) | (IRQ_SRC & ~r_src_prev);
    end

    always_comb begin
        w_pend_word                = '0;
        w_pend_word[IRQ_WIDTH-1:0] = r_irq_pend;
        w_en_word                  = '0;
        w_en_word[IRQ_WIDTH-1:0]   = r_irq_en;
    end

    // Read mux sees current register contents, so a same-cycle write is not visible.
    always_comb begin
        w_rdata_next = '0;
        case (w_rsel)
            SEL_CTRL: begin
                for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                    if (w_ridx == IW'(i)) begin
                        w_rdata_next = r_ctrl[i];
                    end
                end
            end
            SEL_STATUS: w_rdata_next = r_status;
            SEL_PEND:   w_rdata_next = w_pend_word;
            SEL_EN:     w_rdata_next = w_en_word;
            SEL_CNT:    w_rdata_next = r_wr_count;
            default:    w_rdata_next = '0;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                r_ctrl[i] <= CTRL_RESET_VAL;
            end
            r_status   <= '0;
            r_irq_pend <= '0;
            r_irq_en   <= '0;
            r_src_prev <= '0;
            r_wr_count <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_irq      <= 1'b0;
            r_dec_err  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                if (WEN && (w_wsel == SEL_CTRL) && (w_widx == IW'(i))) begin
                    r_ctrl[i] <= WDATA;
                end
            end
            r_status   <= STATUS_IN;
            r_src_prev <= IRQ_SRC;
            r_irq_pend <= w_pend_next;
            if (WEN && (w_wsel == SEL_EN)) begin
                r_irq_en <= WDATA[IRQ_WIDTH-1:0];
            end
            r_irq <= |(r_irq_pend & r_irq_en);
            if (WEN && (w_wsel == SEL_CNT)) begin
                r_wr_count <= '0;
            end else if (WACK) begin
                r_wr_count <= r_wr_count + DATA_WIDTH'(1);
            end
            r_rvalid <= REN;
            if (REN) begin
                r_rdata <= w_rdata_next;
            end
            r_dec_err <= (WEN && (w_wsel == SEL_NONE)) || (REN && (w_rsel == SEL_NONE));
        end
    end

    always_comb begin
        CTRL_OUT = '0;
        for (int unsigned i = 0; i < NUM_CTRL; i++) begin
            CTRL_OUT[i*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[i];
        end
    end

    assign RDATA   = r_rdata;
    assign RVALID  = r_rvalid;
    assign IRQ     = r_irq;
    assign DEC_ERR = r_dec_err;

endmodule

// File: tb/tb_native_regbank.sv
// tb_native_regbank
//   Directed bench for native_regbank (DATA_WIDTH 32, BASE_ADDR 0x1000,
//   NUM_CTRL 4, CTRL_RESET_VAL 0xC3, IRQ_WIDTH 8). Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
module tb_native_regbank;

    localparam logic [31:0] B      = 32'h0000_1000;
    localparam logic [31:0] RSTV   = 32'h0000_00C3;
    localparam logic [31:0] STATV  = 32'h1234_5678;
    localparam logic [31:0] A_STAT = B + 32'h10;
    localparam logic [31:0] A_PEND = B + 32'h14;
    localparam logic [31:0] A_EN   = B + 32'h18;
    localparam logic [31:0] A_CNT  = B + 32'h1C;

    logic         clk;
    logic         rst_n;
    logic         WEN;
    logic [31:0]  WADDR;
    logic [31:0]  WDATA;
    logic         WACK;
    logic         REN;
    logic [31:0]  RADDR;
    logic [31:0]  RDATA;
    logic         RVALID;
    logic [127:0] CTRL_OUT;
    logic [31:0]  STATUS_IN;
    logic [7:0]   IRQ_SRC;
    logic         IRQ;
    logic         DEC_ERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] d;
    logic        v1, v2, de;
    logic [31:0] rst_exp [8];

    native_regbank #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .BASE_ADDR      (B),
        .NUM_CTRL       (4),
        .CTRL_RESET_VAL (RSTV),
        .IRQ_WIDTH      (8)
    ) dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rst_n),
        .WEN         (WEN),
        .WADDR       (WADDR),
        .WDATA       (WDATA),
        .WACK        (WACK),
        .REN         (REN),
        .RADDR       (RADDR),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .CTRL_OUT    (CTRL_OUT),
        .STATUS_IN   (STATUS_IN),
        .IRQ_SRC     (IRQ_SRC),
        .IRQ         (IRQ),
        .DEC_ERR     (DEC_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drivers only: return what the DUT produced, the tests do the comparing.
    task automatic rd(input logic [31:0] a, output logic [31:0] od, output logic ov1,
                      output logic ov2, output logic ode);
        @(negedge clk); REN = 1'b1; RADDR = a;
        @(negedge clk); REN = 1'b0; od = RDATA; ov1 = RVALID; ode = DEC_ERR;
        @(negedge clk); ov2 = RVALID;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat, output logic ode);
        @(negedge clk); WEN = 1'b1; WADDR = a; WDATA = dat;
        @(negedge clk); WEN = 1'b0; ode = DEC_ERR;
    endtask

    task automatic test_reset;
        n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", RVALID); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
        n_checks++; if (DEC_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_decerr: got %b expected 0", DEC_ERR); end
        n_checks++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", RDATA); end
        n_checks++; if (CTRL_OUT !== {4{RSTV}}) begin n_fail++; $display("FAIL reset_ctrl_out: got %h expected %h", CTRL_OUT, {4{RSTV}}); end
        for (int i = 0; i < 8; i++) begin
            rd(B + 32'(i * 4), d, v1, v2, de);
            n_checks++; if (d !== rst_exp[i]) begin n_fail++; $display("FAIL reset_word%0d: got %h expected %h", i, d, rst_exp[i]); end
            n_checks++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid_hi%0d: got %b expected 1", i, v1); end
            n_checks++; if (v2 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_lo%0d: got %b expected 0", i, v2); end
            n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_decerr%0d: got %b expected 0", i, de); end
        end
    endtask

    task automatic test_ctrl_rw;
        wr(B + 32'h8, 32'hA5A5_0001, de);
        rd(B + 32'h8, d, v1, v2, de);
        n_checks++; if (d !== 32'hA5A5_0001) begin n_fail++; $display("FAIL ctrl2_read: got %h expected a5a50001", d); end
        n_checks++; if (CTRL_OUT[95:64] !== 32'hA5A5_0001) begin n_fail++; $display("FAIL ctrl2_out: got %h expected a5a50001", CTRL_OUT[95:64]); end
        n_checks++; if (CTRL_OUT[31:0] !== RSTV) begin n_fail++; $display("FAIL ctrl0_untouched: got %h expected %h", CTRL_OUT[31:0], RSTV); end
        repeat (2) @(negedge clk);
        n_checks++; if (RDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rdata_hold: got %h expected a5a50001", RDATA); end
        // Same-cycle write and read of CTRL[2]: read sees the old contents.
        @(negedge clk);
        WEN = 1'b1; WADDR = B + 32'h8; WDATA = 32'h1111_2222;
        REN = 1'b1; RADDR = B + 32'h8;
        @(negedge clk);
        WEN = 1'b0; REN = 1'b0;
        n_checks++; if (RDATA !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rw_same_cycle_old: got %h expected a5a50001", RDATA); end
        n_checks++; if (RVALID !== 1'b1) begin n_fail++; $display("FAIL rw_same_cycle_rvalid: got %b expected 1", RVALID); end
        rd(B + 32'h8, d, v1, v2, de);
        n_checks++; if (d !== 32'h1111_2222) begin n_fail++; $display("FAIL rw_same_cycle_new: got %h expected 11112222", d); end
        wr(B + 32'hC, 32'h0BAD_F00D, de);
        n_checks++; if (CTRL_OUT[127:96] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ctrl3_out: got %h expected 0badf00d", CTRL_OUT[127:96]); end
    endtask

    task automatic test_irq;
        wr(A_EN, 32'hFFFF_FF08, de);
        rd(A_EN, d, v1, v2, de);
        n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL irq_en_mask: got %h expected 00000008", d); end
        @(negedge clk); IRQ_SRC = 8'h08;
        @(negedge clk);
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_latency_early: got %b expected 0", IRQ); end
        @(negedge clk);
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_assert: got %b expected 1", IRQ); end
        rd(A_PEND, d, v1, v2, de);
        n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL irq_pend_set: got %h expected 00000008", d); end
        wr(A_PEND, 32'h0000_0008, de);
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_clear_latency: got %b expected 1", IRQ); end
        @(negedge clk);
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", IRQ); end
        // Source still high: a level is not an edge, pending stays clear.
        rd(A_PEND, d, v1, v2, de);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL irq_level_no_reset: got %h expected 00000000", d); end
        @(negedge clk); IRQ_SRC = 8'h00;
        @(negedge clk);
        @(negedge clk);
        IRQ_SRC = 8'h08; WEN = 1'b1; WADDR = A_PEND; WDATA = 32'h0000_0008;
        @(negedge clk); WEN = 1'b0;
        rd(A_PEND, d, v1, v2, de);
        n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL irq_set_beats_clear: got %h expected 00000008", d); end
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_after_set_wins: got %b expected 1", IRQ); end
        @(negedge clk); IRQ_SRC = 8'h00;
        wr(A_PEND, 32'hFFFF_FFFF, de);
        wr(A_EN, 32'h0, de);
        @(negedge clk);
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_final_clear: got %b expected 0", IRQ); end
    endtask

    task automatic test_wr_count;
        repeat (5) begin
            @(negedge clk); WACK = 1'b1;
            @(negedge clk); WACK = 1'b0;
        end
        rd(A_CNT, d, v1, v2, de);
        n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL wrcount_five: got %0d expected 5", d); end
        wr(A_CNT, 32'h0000_1234, de);
        n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL wrcount_write_decerr: got %b expected 0", de); end
        rd(A_CNT, d, v1, v2, de);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL wrcount_cleared: got %0d expected 0", d); end
        repeat (2) begin
            @(negedge clk); WACK = 1'b1;
            @(negedge clk); WACK = 1'b0;
        end
        rd(A_CNT, d, v1, v2, de);
        n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL wrcount_two: got %0d expected 2", d); end
        @(negedge clk);
        WACK = 1'b1; WEN = 1'b1; WADDR = A_CNT; WDATA = 32'hFFFF_FFFF;
        @(negedge clk);
        WACK = 1'b0; WEN = 1'b0;
        rd(A_CNT, d, v1, v2, de);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL wrcount_clear_wins: got %0d expected 0", d); end
    endtask

    task automatic test_unmapped;
        rd(B + 32'h8, d, v1, v2, de);
        n_checks++; if (d !== 32'h1111_2222) begin n_fail++; $display("FAIL unmapped_pre_read: got %h expected 11112222", d); end
        rd(B + 32'h100, d, v1, v2, de);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_rdata: got %h expected 00000000", d); end
        n_checks++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL unmapped_rvalid: got %b expected 1", v1); end
        n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL unmapped_rd_decerr: got %b expected 1", de); end
        n_checks++; if (DEC_ERR !== 1'b0) begin n_fail++; $display("FAIL unmapped_decerr_pulse: got %b expected 0", DEC_ERR); end
        wr(B + 32'h100, 32'hFFFF_FFFF, de);
        n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_decerr: got %b expected 1", de); end
        n_checks++; if (CTRL_OUT !== {32'h0BAD_F00D, 32'h1111_2222, RSTV, RSTV}) begin n_fail++; $display("FAIL unmapped_wr_no_effect: got %h", CTRL_OUT); end
        rd(A_EN, d, v1, v2, de);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_wr_en: got %h expected 00000000", d); end
        rd(B + 32'h20, d, v1, v2, de);
        n_checks++; if (de !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL past_last_word: got de=%b d=%h expected de=1 d=0", de, d); end
        rd(B - 32'h4, d, v1, v2, de);
        n_checks++; if (de !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL below_base: got de=%b d=%h expected de=1 d=0", de, d); end
        rd(B, d, v1, v2, de);
        n_checks++; if (de !== 1'b0 || d !== RSTV) begin n_fail++; $display("FAIL base_word: got de=%b d=%h expected de=0 d=%h", de, d, RSTV); end
        wr(A_STAT, 32'hDEAD_BEEF, de);
        n_checks++; if (de !== 1'b0) begin n_fail++; $display("FAIL status_write_decerr: got %b expected 0", de); end
        rd(A_STAT, d, v1, v2, de);
        n_checks++; if (d !== STATV) begin n_fail++; $display("FAIL status_readonly: got %h expected %h", d, STATV); end
        @(negedge clk);
        WEN = 1'b1; WADDR = B + 32'h100; WDATA = 32'h5;
        REN = 1'b1; RADDR = B - 32'h8;
        @(negedge clk);
        WEN = 1'b0; REN = 1'b0;
        n_checks++; if (DEC_ERR !== 1'b1) begin n_fail++; $display("FAIL both_unmapped_pulse: got %b expected 1", DEC_ERR); end
        @(negedge clk);
        n_checks++; if (DEC_ERR !== 1'b0) begin n_fail++; $display("FAIL both_unmapped_single: got %b expected 0", DEC_ERR); end
    endtask

    task automatic test_reset_mid;
        wr(A_EN, 32'h0000_0001, de);
        @(negedge clk); IRQ_SRC = 8'h01;
        @(negedge clk); IRQ_SRC = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", IRQ); end
        @(negedge clk); WACK = 1'b1;
        @(negedge clk); WACK = 1'b0;
        @(negedge clk);
        REN = 1'b1; RADDR = B + 32'h8;
        WEN = 1'b1; WADDR = B + 32'h4; WDATA = 32'h7777_7777;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_mid_rvalid_edge: got %b expected 0", RVALID); end
        @(negedge clk);
        REN = 1'b0; WEN = 1'b0;
        n_checks++; if (CTRL_OUT !== {4{RSTV}}) begin n_fail++; $display("FAIL reset_mid_ctrl: got %h expected %h", CTRL_OUT, {4{RSTV}}); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_mid_irq: got %b expected 0", IRQ); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_replay: got %b expected 0", RVALID); end
        n_checks++; if (CTRL_OUT[63:32] !== RSTV) begin n_fail++; $display("FAIL reset_mid_write_dropped: got %h expected %h", CTRL_OUT[63:32], RSTV); end
        for (int i = 0; i < 8; i++) begin
            rd(B + 32'(i * 4), d, v1, v2, de);
            n_checks++; if (d !== rst_exp[i]) begin n_fail++; $display("FAIL reset_mid_word%0d: got %h expected %h", i, d, rst_exp[i]); end
        end
    endtask

    initial begin
        rst_exp[0] = RSTV; rst_exp[1] = RSTV; rst_exp[2] = RSTV; rst_exp[3] = RSTV;
        rst_exp[4] = STATV; rst_exp[5] = 32'h0; rst_exp[6] = 32'h0; rst_exp[7] = 32'h0;
        rst_n = 1'b0; WEN = 1'b0; WADDR = '0; WDATA = '0; WACK = 1'b0;
        REN = 1'b0; RADDR = '0; STATUS_IN = STATV; IRQ_SRC = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_ctrl_rw;
        test_irq;
        test_wr_count;
        test_unmapped;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/native_regbank.md
Name: native_regbank

Overview:
- Register bank on the native side of the AXI4-Lite-to-native bridge. Consumes WEN/WADDR/WDATA/WACK/REN/RADDR and returns RDATA/RVALID.
- Holds NUM_CTRL read/write control registers, one sampled status register, an interrupt block (pending W1C plus enable), and a write-completion counter.
- Drives the control outputs and the IRQ line into the datapath.

Parameters:
- DATA_WIDTH, 32, data width in bits; 32 or 64.
- ADDR_WIDTH, 32, byte-address width.
- BASE_ADDR, 0, byte base address of the bank; must be word-aligned.
- NUM_CTRL, 4, number of control registers; 1..16.
- CTRL_RESET_VAL, 0, reset value of every CTRL register.
- IRQ_WIDTH, 8, number of interrupt sources; at most DATA_WIDTH.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_ARESETN  in  1  asynchronous active-low reset.
- WEN  in  1  write strobe, one cycle.
- WADDR  in  ADDR_WIDTH  write byte address.
- WDATA  in  DATA_WIDTH  write data.
- WACK  in  1  write completion pulse (B handshake done).
- REN  in  1  read strobe, one cycle.
- RADDR  in  ADDR_WIDTH  read byte address.
- RDATA  out  DATA_WIDTH  read data, held until the next read.
- RVALID  out  1  read data valid, one-cycle pulse.
- CTRL_OUT  out  NUM_CTRL*DATA_WIDTH  flattened CTRL registers; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- STATUS_IN  in  DATA_WIDTH  live status from the datapath.
- IRQ_SRC  in  IRQ_WIDTH  level interrupt sources.
- IRQ  out  1  interrupt request.
- DEC_ERR  out  1  one-cycle pulse on an access to an unmapped address.

Behaviour:
- Reset: asynchronous on AXI_ARESETN low.
  - CTRL = CTRL_RESET_VAL; STATUS shadow = 0; IRQ_PEND = 0; IRQ_EN = 0; WR_COUNT = 0; IRQ_SRC history = 0.
  - RDATA = 0, RVALID = 0, IRQ = 0, DEC_ERR = 0.
- Decode:
  - idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low address bits are ignored.
  - Any address below BASE_ADDR is unmapped.
- Word map:
  - idx 0..NUM_CTRL-1: CTRL[idx], read/write.
  - NUM_CTRL: STATUS, read-only. Shadow register loads STATUS_IN every cycle.
  - NUM_CTRL+1: IRQ_PEND, W1C. Only the low IRQ_WIDTH bits are implemented; upper bits read 0.
  - NUM_CTRL+2: IRQ_EN, read/write, low IRQ_WIDTH bits.
  - NUM_CTRL+3: WR_COUNT, read-only counter of WACK pulses. It wraps at 2^DATA_WIDTH. Any write to it clears it to 0.
  - Any other idx is unmapped.
- Write: on the WEN cycle the target updates at the next edge. Writes to STATUS are ignored with no error.
- Read: REN at cycle N → RDATA loaded and RVALID=1 at cycle N+1. RVALID is high for exactly one cycle; RDATA holds afterwards. Read latency is fixed at 1.
- Simultaneous WEN and REN to the same register: the read returns the pre-write value.
- Unmapped access:
  - Read returns 0 with RVALID asserted as normal; writes have no effect.
  - DEC_ERR pulses one cycle after the offending REN/WEN. When both are unmapped in the same cycle, it pulses once.
- IRQ_PEND bit k:
  - Set on a rising edge of IRQ_SRC[k], detected against a registered previous value.
  - Cleared by writing 1 to bit k.
  - A set and a clear in the same cycle: set wins.
- IRQ is registered: IRQ = |(IRQ_PEND & IRQ_EN), one cycle after either register changes.
- WR_COUNT: increments on each WACK. When WACK and a write to WR_COUNT land in the same cycle, the clear wins and the result is 0.
- Reset asserted mid-access clears RVALID and any pending update. Nothing is replayed after reset releases.

Test Plan:
- Reset, then read all NUM_CTRL+4 words → CTRL=CTRL_RESET_VAL; STATUS = STATUS_IN; others 0; each RVALID is one cycle exactly one cycle after REN.
- Write 0xA5A5_0001 to CTRL[2] (addr BASE+8), then read it → RDATA=0xA5A5_0001 and CTRL_OUT slice 2 matches; a same-cycle REN to CTRL[2] returns the old value.
- IRQ_SRC[3] 0→1 with IRQ_EN=0x08 → IRQ_PEND=0x08 and IRQ=1 one cycle later; write 0x08 to IRQ_PEND → IRQ=0; a clear coinciding with a new edge leaves the bit set.
- Five WACK pulses → WR_COUNT reads 5; write any value to it → reads 0; a WACK in the same cycle as that write still yields 0.
- Read of BASE+0x100 → RDATA=0, RVALID=1, DEC_ERR pulse; a write to the same address changes no register.
- Assert AXI_ARESETN low between REN and RVALID → RVALID never rises and all registers return to reset values.
